// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t           : sequencing FSM state encoding
//   MemTimeoutDefault : default number of not-ready memory cycles tolerated
//   RegZero           : architectural $zero register index
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StError   = 2'd2
  } state_t;

  localparam int unsigned MemTimeoutDefault = 16;
  localparam logic [4:0]  RegZero           = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection for the 5-stage pipeline.
// Inputs : ID-stage source fields (IDRsIn, IDRtIn, IDUsesRtIn), EX-stage load
//          info (IDEXMemReadIn, IDEXRegDstIn), branch resolution (BranchTakenIn).
// Outputs: LoadUseOut - instruction in ID needs the result of the load in EX.
//          BranchOut  - taken branch/jump in EX requires a redirect.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] IDRsIn,
  input  logic [4:0] IDRtIn,
  input  logic       IDUsesRtIn,
  input  logic       IDEXMemReadIn,
  input  logic [4:0] IDEXRegDstIn,
  input  logic       BranchTakenIn,
  output logic       LoadUseOut,
  output logic       BranchOut
);

  logic rsMatch;
  logic rtMatch;

  always_comb begin
    rsMatch    = (IDEXRegDstIn == IDRsIn);
    rtMatch    = IDUsesRtIn && (IDEXRegDstIn == IDRtIn);
    // Loads to $zero never produce a value, so they cannot create a dependence.
    LoadUseOut = IDEXMemReadIn && (IDEXRegDstIn != RegZero) && (rsMatch || rtMatch);
    BranchOut  = BranchTakenIn;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencing unit for the 5-stage MIPS pipeline.
// Inputs : Clk, Rst (synchronous, active-high), ID/EX hazard fields, BranchTakenIn,
//          EXMEMMemAccessIn/MemReadyIn memory handshake.
// Outputs: PC and pipeline-register write/flush controls (Mealy, same-cycle),
//          MemErrorOut (sticky timeout error), StallCntOut (saturating count of
//          cycles with PCWriteOut low).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [4:0]             IDRsIn,
  input  logic [4:0]             IDRtIn,
  input  logic                   IDUsesRtIn,
  input  logic                   IDEXMemReadIn,
  input  logic [4:0]             IDEXRegDstIn,
  input  logic                   BranchTakenIn,
  input  logic                   EXMEMMemAccessIn,
  input  logic                   MemReadyIn,
  output logic                   PCWriteOut,
  output logic                   IFIDWriteOut,
  output logic                   IFIDFlushOut,
  output logic                   IDEXWriteOut,
  output logic                   IDEXFlushOut,
  output logic                   EXMEMWriteOut,
  output logic                   MEMWBFlushOut,
  output logic                   MemErrorOut,
  output logic [STALL_CNT_W-1:0] StallCntOut
);

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_t                 stateQ, stateD;
  logic [7:0]             waitCntQ, waitCntD;
  logic                   memErrQ, memErrD;
  logic [STALL_CNT_W-1:0] stallCntQ, stallCntD;

  logic loadUse;
  logic branch;
  logic freeze;

  hazard_detect uHazardDetect (
    .IDRsIn        (IDRsIn),
    .IDRtIn        (IDRtIn),
    .IDUsesRtIn    (IDUsesRtIn),
    .IDEXMemReadIn (IDEXMemReadIn),
    .IDEXRegDstIn  (IDEXRegDstIn),
    .BranchTakenIn (BranchTakenIn),
    .LoadUseOut    (loadUse),
    .BranchOut     (branch)
  );

  assign freeze = EXMEMMemAccessIn && !MemReadyIn;

  // Next-state: FSM, consecutive-freeze counter and sticky error.
  always_comb begin
    stateD   = stateQ;
    waitCntD = waitCntQ;
    memErrD  = memErrQ;
    if (Rst) begin
      stateD   = StRun;
      waitCntD = 8'd0;
      memErrD  = 1'b0;
    end else begin
      unique case (stateQ)
        StRun, StMemWait: begin
          if (freeze) begin
            if (waitCntQ == WaitLast) begin
              stateD   = StError;
              waitCntD = 8'd0;
              memErrD  = 1'b1;
            end else begin
              stateD   = StMemWait;
              waitCntD = waitCntQ + 8'd1;
            end
          end else begin
            stateD   = StRun;
            waitCntD = 8'd0;
          end
        end
        StError: stateD = StError;
        default: begin
          stateD   = StRun;
          waitCntD = 8'd0;
        end
      endcase
    end
  end

  // Control outputs, priority: reset > error > memory freeze > branch > load-use.
  always_comb begin
    PCWriteOut    = 1'b1;
    IFIDWriteOut  = 1'b1;
    IFIDFlushOut  = 1'b0;
    IDEXWriteOut  = 1'b1;
    IDEXFlushOut  = 1'b0;
    EXMEMWriteOut = 1'b1;
    MEMWBFlushOut = 1'b0;
    if (Rst) begin
      PCWriteOut    = 1'b0;
      IFIDWriteOut  = 1'b0;
      IFIDFlushOut  = 1'b1;
      IDEXWriteOut  = 1'b0;
      IDEXFlushOut  = 1'b1;
      EXMEMWriteOut = 1'b0;
      MEMWBFlushOut = 1'b1;
    end else if (stateQ == StError || freeze) begin
      // Hold everything upstream of MEM and bubble WB until the access ends.
      PCWriteOut    = 1'b0;
      IFIDWriteOut  = 1'b0;
      IDEXWriteOut  = 1'b0;
      EXMEMWriteOut = 1'b0;
      MEMWBFlushOut = 1'b1;
    end else if (branch) begin
      // Wrong-path instructions in IF and ID are squashed; PC takes the target.
      IFIDFlushOut = 1'b1;
      IDEXFlushOut = 1'b1;
    end else if (loadUse) begin
      PCWriteOut   = 1'b0;
      IFIDWriteOut = 1'b0;
      IDEXFlushOut = 1'b1;
    end
  end

  always_comb begin
    stallCntD = stallCntQ;
    if (Rst) begin
      stallCntD = '0;
    end else if (!PCWriteOut && (stallCntQ != '1)) begin
      stallCntD = stallCntQ + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    stateQ    <= stateD;
    waitCntQ  <= waitCntD;
    memErrQ   <= memErrD;
    stallCntQ <= stallCntD;
  end

  assign MemErrorOut = memErrQ;
  assign StallCntOut = stallCntQ;

endmodule
